// File: rtl/transmitter.sv
// Serial frame transmitter: sync marker, a quiet gap, then 16 data bits LSB first
// on a divided data clock whose falling edge is the receiver's sample point.
module transmitter #(
    parameter int HALF_PER    = 4,
    parameter int SYNC_CYCLES = 8
) (
    input  logic        cClk,
    input  logic        reset,
    input  logic [15:0] word,
    input  logic        load,
    output logic        ready,
    output logic        done,
    output logic        sync,
    output logic        dClk,
    output logic        data
);

    typedef enum logic [1:0] {IDLE, SYNC, GAP, SHIFT} state_t;

    localparam logic [7:0] HALF_LOAD = 8'(HALF_PER - 1);
    localparam logic [7:0] SYNC_LOAD = 8'(SYNC_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [3:0]  bit_reg, bit_next;
    logic [15:0] shift_reg, shift_next;
    logic        ready_reg, ready_next;
    logic        done_reg, done_next;
    logic        sync_reg, sync_next;
    logic        dclk_reg, dclk_next;
    logic        data_reg, data_next;

    // Outputs are computed for the coming cycle and registered, so nothing
    // combinational reaches a pin.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        ready_next = ready_reg;
        done_next  = 1'b0;
        sync_next  = sync_reg;
        dclk_next  = dclk_reg;
        data_next  = data_reg;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                sync_next  = 1'b0;
                dclk_next  = 1'b0;
                data_next  = 1'b0;
                if (load) begin
                    state_next = SYNC;
                    cnt_next   = SYNC_LOAD;
                    shift_next = word;
                    ready_next = 1'b0;
                    sync_next  = 1'b1;
                end
            end
            SYNC: begin
                if (cnt_reg == 8'd0) begin
                    state_next = GAP;
                    cnt_next   = HALF_LOAD;
                    sync_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            GAP: begin
                if (cnt_reg == 8'd0) begin
                    state_next = SHIFT;
                    cnt_next   = HALF_LOAD;
                    bit_next   = 4'd0;
                    dclk_next  = 1'b1;
                    data_next  = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else if (dclk_reg) begin
                    // High phase over: drop dClk, data stays put through the low phase.
                    dclk_next = 1'b0;
                    cnt_next  = HALF_LOAD;
                end else if (bit_reg == 4'd15) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                    bit_next   = 4'd0;
                    shift_next = 16'd0;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                    data_next  = 1'b0;
                end else begin
                    bit_next   = bit_reg + 4'd1;
                    shift_next = shift_reg >> 1;
                    cnt_next   = HALF_LOAD;
                    dclk_next  = 1'b1;
                    data_next  = shift_reg[1];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge cClk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            bit_reg   <= 4'd0;
            shift_reg <= 16'd0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            dclk_reg  <= 1'b0;
            data_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            ready_reg <= ready_next;
            done_reg  <= done_next;
            sync_reg  <= sync_next;
            dclk_reg  <= dclk_next;
            data_reg  <= data_next;
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign sync  = sync_reg;
    assign dClk  = dclk_reg;
    assign data  = data_reg;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: frame timing, bit order via a dClk-fall receiver
// model, ignored loads, back-to-back frames, mid-frame reset, short parameters.
module tb_transmitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] word = 16'd0;
    logic        load4 = 1'b0;
    logic        load3 = 1'b0;

    logic r4, d4, s4, k4, q4;
    logic r3, d3, s3, k3, q3;

    transmitter u_dut4 (
        .cClk(clk), .reset(reset), .word(word), .load(load4),
        .ready(r4), .done(d4), .sync(s4), .dClk(k4), .data(q4)
    );

    transmitter #(.HALF_PER(3), .SYNC_CYCLES(3)) u_dut3 (
        .cClk(clk), .reset(reset), .word(word), .load(load3),
        .ready(r3), .done(d3), .sync(s3), .dClk(k3), .data(q3)
    );

    always #5 clk = ~clk;

    logic sel = 1'b0;
    logic s_ready, s_done, s_sync, s_dclk, s_data;
    assign s_ready = sel ? r3 : r4;
    assign s_done  = sel ? d3 : d4;
    assign s_sync  = sel ? s3 : s4;
    assign s_dclk  = sel ? k3 : k4;
    assign s_data  = sel ? q3 : q4;

    int tests = 0;
    int failed = 0;

    // Frame statistics gathered by capture
    int          frame_len, sync_cnt, first_dclk, falls, viol, ready_bad, first_sync, done_dclk;
    logic        got_done;
    logic [15:0] rx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_load(input logic v);
        if (sel) load3 = v;
        else     load4 = v;
    endtask

    // Called right after the acceptance edge; samples every cycle on the falling clock.
    task automatic capture(input logic noise, input logic keep, input logic [15:0] next_w);
        logic pd, pdat;
        pd = 1'b0; pdat = 1'b0;
        frame_len = 0; sync_cnt = 0; first_dclk = 0; falls = 0; viol = 0;
        ready_bad = 0; first_sync = 0; done_dclk = 0; got_done = 1'b0; rx = 16'd0;
        for (int c = 0; c < 600 && !got_done; c++) begin
            @(negedge clk);
            if (s_done) begin
                got_done  = 1'b1;
                done_dclk = int'(s_dclk) + int'(s_data) + int'(!s_ready);
                if (keep) word = next_w;
                else      set_load(1'b0);
            end else begin
                frame_len++;
                if (noise) begin
                    set_load(1'b1);
                    word = 16'($urandom);
                end else if (!keep) begin
                    set_load(1'b0);
                end
                if (frame_len == 1) first_sync = int'(s_sync);
                if (s_sync) sync_cnt++;
                if (s_ready) ready_bad++;
                if (s_dclk && !pd && first_dclk == 0) first_dclk = frame_len;
                if (!s_dclk && pd) begin
                    falls++;
                    rx = {s_data, rx[15:1]};
                end
                if (s_data !== pdat && !(s_dclk && !pd)) viol++;
                pd = s_dclk;
                pdat = s_data;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] w, input int sy, input int hp);
        $display("[TB] %s: sent=%h rx=%h len=%0d sync=%0d falls=%0d", tag, w, rx, frame_len, sync_cnt, falls);
        check({tag, "_rx"},         32'(rx),         32'(w));
        check({tag, "_len"},        32'(frame_len),  32'(sy + hp + 32 * hp));
        check({tag, "_sync_cnt"},   32'(sync_cnt),   32'(sy));
        check({tag, "_first_sync"}, 32'(first_sync), 32'd1);
        check({tag, "_first_dclk"}, 32'(first_dclk), 32'(sy + hp + 1));
        check({tag, "_falls"},      32'(falls),      32'd16);
        check({tag, "_data_hold"},  32'(viol),       32'd0);
        check({tag, "_ready_low"},  32'(ready_bad),  32'd0);
        check({tag, "_done_cycle"}, 32'(done_dclk),  32'd0);
    endtask

    task automatic start(input logic [15:0] w);
        word = w;
        set_load(1'b1);
    endtask

    initial begin
        int pd, fc, dclk_hi;

        // Reset state
        #12;
        check("rst_ready", 32'(r4), 32'd1);
        check("rst_sync",  32'(s4), 32'd0);
        check("rst_dclk",  32'(k4), 32'd0);
        check("rst_data",  32'(q4), 32'd0);
        check("rst_done",  32'(d4), 32'd0);
        check("rst_ready3", 32'(r3), 32'd1);

        // Load accepted on the first edge after reset release
        @(negedge clk);
        reset = 1'b1;
        start(16'hA5C3);
        capture(1'b0, 1'b0, 16'h0);
        check_frame("a5c3", 16'hA5C3, 8, 4);
        @(negedge clk);
        check("done_one_cycle", 32'(d4), 32'd0);
        check("ready_after",    32'(r4), 32'd1);

        // Loopback patterns
        start(16'h0000); capture(1'b0, 1'b0, 16'h0); check_frame("p0000", 16'h0000, 8, 4);
        @(negedge clk);
        start(16'hFFFF); capture(1'b0, 1'b0, 16'h0); check_frame("pffff", 16'hFFFF, 8, 4);
        @(negedge clk);
        start(16'h8001); capture(1'b0, 1'b0, 16'h0); check_frame("p8001", 16'h8001, 8, 4);

        // Loads and word changes during a frame are ignored
        @(negedge clk);
        start(16'h3C5A); capture(1'b1, 1'b0, 16'h0); check_frame("noise", 16'h3C5A, 8, 4);

        // load held high: back-to-back frames
        @(negedge clk);
        start(16'h1357); capture(1'b0, 1'b1, 16'h9ABC); check_frame("b2b_1", 16'h1357, 8, 4);
        capture(1'b0, 1'b0, 16'h0); check_frame("b2b_2", 16'h9ABC, 8, 4);

        // Reset during bit 7
        @(negedge clk);
        start(16'hBEEF);
        pd = 0; fc = 0;
        for (int c = 0; c < 300 && fc < 7; c++) begin
            @(negedge clk);
            load4 = 1'b0;
            if (!k4 && pd == 1) fc++;
            pd = int'(k4);
        end
        check("bit7_reached", 32'(fc), 32'd7);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(r4), 32'd1);
        check("abort_sync",  32'(s4), 32'd0);
        check("abort_dclk",  32'(k4), 32'd0);
        check("abort_data",  32'(q4), 32'd0);
        check("abort_done",  32'(d4), 32'd0);
        dclk_hi = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (k4) dclk_hi++;
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (k4 || s4 || !r4) dclk_hi++;
        end
        check("abort_quiet", 32'(dclk_hi), 32'd0);
        $display("[TB] reset at bit 7: outputs cleared, idle after release");
        start(16'h1234); capture(1'b0, 1'b0, 16'h0); check_frame("after_rst", 16'h1234, 8, 4);

        // HALF_PER=3, SYNC_CYCLES=3 instance
        @(negedge clk);
        sel = 1'b1;
        #1;
        start(16'hC0DE); capture(1'b0, 1'b0, 16'h0); check_frame("short", 16'hC0DE, 3, 3);
        check("short_len102", 32'(frame_len), 32'd102);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
